// File: rtl/axi_multi_port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_multi_port_bridge
// Description : Bridges NRD L1 read requesters and one dcache write port onto
//               a single AXI3 master interface.
//               Read side : round-robin AR arbitration, one address in flight,
//                           R beats routed back to the requester named by rid.
//               Write side: single outstanding burst, AW and W issued
//                           concurrently, retired on the B handshake.
//               Optional  : define BRIDGE_RAW_CHECK_EN to block reads that hit
//                           the line of the pending (or just-accepted) write.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, resetn                     clock, synchronous active-low reset
//   rd_req/rd_addr/rd_type          per-requester read request (32b addr, 3b type)
//   rd_addr_ok/rd_data_ok/rd_last   per-requester accept / data / last strobes
//   rd_rdata                        returned read word, shared by all requesters
//   wr_req/wr_addr/wr_type          write request, address, type
//   wr_data/wr_wstrb                full line data (beat k = [32k +: 32]), strobe
//   wr_addr_ok/wr_done              write accept, 1-cycle completion pulse
//   ar*/r*/aw*/w*/b*                AXI3 master channels (5-bit ids so that the
//                                   write id NRD still fits when NRD = 16)
// ============================================================================
module axi_multi_port_bridge #(
  parameter int NRD        = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  // read requesters
  input  logic [NRD-1:0]          rd_req,
  input  logic [32*NRD-1:0]       rd_addr,
  input  logic [3*NRD-1:0]        rd_type,
  output logic [NRD-1:0]          rd_addr_ok,
  output logic [NRD-1:0]          rd_data_ok,
  output logic [31:0]             rd_rdata,
  output logic [NRD-1:0]          rd_last,
  // write port
  input  logic                    wr_req,
  input  logic [31:0]             wr_addr,
  input  logic [2:0]              wr_type,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  input  logic [3:0]              wr_wstrb,
  output logic                    wr_addr_ok,
  output logic                    wr_done,
  // AXI3 AR
  output logic [4:0]              arid,
  output logic [31:0]             araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI3 R
  input  logic [4:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // AXI3 AW
  output logic [4:0]              awid,
  output logic [31:0]             awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI3 W
  output logic [4:0]              wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI3 B
  input  logic [4:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int         PTR_W     = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int         CNT_W     = $clog2(LINE_WORDS);
  localparam int         LOFF      = $clog2(LINE_WORDS * 4);
  localparam logic [3:0] LEN_LINE  = 4'(LINE_WORDS - 1);
  localparam logic [4:0] WR_ID     = 5'(NRD);
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_SEND = 1'b1;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_BUSY  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  // (base + k) mod NRD without a divider; k is always < NRD
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NRD) s = s - NRD;
    return PTR_W'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Read address channel
  // ---------------------------------------------------------------------------
  logic [0:0]       ar_state;
  logic [0:0]       ar_next;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic             grant_vld;
  logic             hazard;
  logic             rd_accept;
  logic [31:0]      ar_addr_q;
  logic             ar_line_q;
  logic [PTR_W-1:0] ar_id_q;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant     = rr_ptr;
    grant_vld = 1'b0;
    for (int k = NRD - 1; k >= 0; k--) begin
      if (rd_req[wrap_idx(rr_ptr, k)]) begin
        grant     = wrap_idx(rr_ptr, k);
        grant_vld = 1'b1;
      end
    end
  end

  // Write-side registers, referenced by the hazard compare
  logic [1:0]              w_state;
  logic [1:0]              w_next;
  logic [31:0]             wr_addr_q;
  logic                    wr_line_q;
  logic [32*LINE_WORDS-1:0] wr_data_q;
  logic [3:0]              wr_strb_q;
  logic [CNT_W-1:0]        cnt;
  logic                    aw_done;
  logic                    w_done;
  logic                    pending_wr;

`ifdef BRIDGE_RAW_CHECK_EN
  logic [31:0]      gnt_addr;
  logic [31-LOFF:0] gnt_line;
  assign gnt_addr = rd_addr[32*grant +: 32];
  assign gnt_line = gnt_addr[31:LOFF];
  // A hazardous grant is simply not accepted; rr_ptr only moves on arready,
  // so the same requester stays granted until the write retires.
  assign hazard = (pending_wr && (gnt_line == wr_addr_q[31:LOFF])) ||
                  (wr_req && wr_addr_ok && (gnt_line == wr_addr[31:LOFF]));
`else
  assign hazard = 1'b0;
`endif

  assign rd_accept  = resetn && (ar_state == AR_IDLE) && grant_vld && !hazard;
  assign rd_addr_ok = rd_accept ? (NRD'(1) << grant) : '0;

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      rr_ptr   <= '0;
    end else begin
      ar_state <= ar_next;
      if (arvalid && arready) rr_ptr <= wrap_idx(ar_id_q, 1);
    end
  end

  // next-state logic
  always_comb begin
    ar_next = ar_state;
    case (ar_state)
      AR_IDLE: if (rd_accept) ar_next = AR_SEND;
      AR_SEND: if (arready)   ar_next = AR_IDLE;
      default:                ar_next = AR_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    arvalid = resetn && (ar_state == AR_SEND);
    araddr  = ar_addr_q;
    arlen   = ar_line_q ? LEN_LINE : 4'd0;
    arid    = 5'(ar_id_q);
  end

  // payload latch; held stable through AR_SEND because accepts only happen in AR_IDLE
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      ar_addr_q <= rd_addr[32*grant +: 32];
      ar_line_q <= (rd_type[3*grant +: 3] == TYPE_LINE);
      ar_id_q   <= grant;
    end
  end

  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // ---------------------------------------------------------------------------
  // Read data channel: always ready; ids outside 0..NRD-1 are sunk silently
  // ---------------------------------------------------------------------------
  assign rready   = 1'b1;
  assign rd_rdata = rdata;

  for (genvar i = 0; i < NRD; i++) begin : g_rd_route
    assign rd_data_ok[i] = rvalid && (rid == 5'(i));
    assign rd_last[i]    = rvalid && rlast && (rid == 5'(i));
  end

  // ---------------------------------------------------------------------------
  // Write channels
  // ---------------------------------------------------------------------------
  logic wr_accept;
  logic aw_hs;
  logic w_hs;

  assign wr_accept = resetn && (w_state == W_IDLE) && wr_req;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;

  // state register and per-burst bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state    <= W_IDLE;
      cnt        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      pending_wr <= 1'b0;
      wr_done    <= 1'b0;
    end else begin
      w_state <= w_next;
      wr_done <= 1'b0;
      if (wr_accept) begin
        cnt        <= '0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        pending_wr <= 1'b1;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) begin
        cnt <= cnt + 1'b1;
        if (wlast) w_done <= 1'b1;
      end
      if ((w_state == W_RESP) && bvalid) begin
        wr_done    <= 1'b1;
        pending_wr <= 1'b0;
      end
    end
  end

  // next-state logic: AW and the last W beat may complete in either order
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (wr_accept) w_next = W_BUSY;
      W_BUSY: if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) w_next = W_RESP;
      W_RESP: if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    wr_addr_ok = resetn && (w_state == W_IDLE);
    awvalid    = resetn && (w_state == W_BUSY) && !aw_done;
    wvalid     = resetn && (w_state == W_BUSY) && !w_done;
    bready     = resetn && (w_state == W_RESP);
    awaddr     = wr_addr_q;
    awlen      = wr_line_q ? LEN_LINE : 4'd0;
    wdata      = wr_data_q[32*cnt +: 32];
    wlast      = !wr_line_q || (cnt == CNT_W'(LINE_WORDS - 1));
    wstrb      = wr_strb_q;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wr_addr_q <= wr_addr;
      wr_line_q <= (wr_type == TYPE_LINE);
      wr_data_q <= wr_data;
      wr_strb_q <= wr_wstrb;
    end
  end

  assign awid    = WR_ID;
  assign wid     = WR_ID;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // Response codes and ids are not acted upon by this bridge.
  logic unused_resp;
  assign unused_resp = ^{bid, bresp, rresp};

endmodule
`default_nettype wire

// File: tb/tb_axi_multi_port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_multi_port_bridge
// Description : Self-checking bench for axi_multi_port_bridge (NRD=2,
//               LINE_WORDS=4). A table of AR arbitration vectors plus
//               hand-written write, read-return, RAW and reset sequences.
//               Optional RAW behaviour follows BRIDGE_RAW_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_multi_port_bridge;

  localparam int NRD = 2;
  localparam int LW  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NRD-1:0]    rd_req;
  logic [32*NRD-1:0] rd_addr;
  logic [3*NRD-1:0]  rd_type;
  logic [NRD-1:0]    rd_addr_ok, rd_data_ok, rd_last;
  logic [31:0]       rd_rdata;
  logic              wr_req;
  logic [31:0]       wr_addr;
  logic [2:0]        wr_type;
  logic [32*LW-1:0]  wr_data;
  logic [3:0]        wr_wstrb;
  logic              wr_addr_ok, wr_done;
  logic [4:0]        arid, rid, awid, wid, bid;
  logic [31:0]       araddr, rdata, awaddr, wdata;
  logic [3:0]        arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]        arsize, arprot, awsize, awprot;
  logic [1:0]        arburst, arlock, rresp, awburst, awlock, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_multi_port_bridge #(.NRD(NRD), .LINE_WORDS(LW)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_type(rd_type),
    .rd_addr_ok(rd_addr_ok), .rd_data_ok(rd_data_ok), .rd_rdata(rd_rdata), .rd_last(rd_last),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_type(wr_type), .wr_data(wr_data),
    .wr_wstrb(wr_wstrb), .wr_addr_ok(wr_addr_ok), .wr_done(wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_words [LW];

  typedef struct {
    logic [1:0] req;
    logic [2:0] t0;
    logic [2:0] t1;
    logic [1:0] exp_ok;
    logic [4:0] exp_id;
    logic [3:0] exp_len;
  } ar_vec_t;

  ar_vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One accepted read: request at a negedge, then the AR beat with one stall cycle.
  task automatic ar_txn(input logic [1:0] req, input logic [5:0] typ, input logic [63:0] addrs,
                        input logic [1:0] exp_ok, input logic [4:0] exp_id,
                        input logic [3:0] exp_len, input logic [31:0] exp_addr);
    @(negedge clk);
    rd_req = req; rd_type = typ; rd_addr = addrs; arready = 1'b0;
    #1;
    check("rd_addr_ok", rd_addr_ok, exp_ok);
    @(negedge clk);
    rd_req = '0;
    #1;
    check("arvalid_on", arvalid, 1'b1);
    check("arid", arid, exp_id);
    check("arlen", arlen, exp_len);
    check("araddr", araddr, exp_addr);
    check("arsize_arburst", {arsize, arburst}, {3'b010, 2'b01});
    @(negedge clk);
    #1;
    check("arvalid_stall", {arvalid, araddr}, {1'b1, exp_addr});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1;
    check("arvalid_off", arvalid, 1'b0);
  endtask

  task automatic start_write(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s);
    @(negedge clk);
    wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s;
    wr_data = {exp_words[3], exp_words[2], exp_words[1], exp_words[0]};
    #1;
    check("wr_addr_ok_idle", wr_addr_ok, 1'b1);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  // Drain W/AW (awready withheld for awdly cycles), then answer B.
  task automatic finish_write(input logic [31:0] ea, input logic [3:0] elen,
                              input logic [3:0] es, input int nbeats, input int awdly);
    int  beats = 0;
    int  aws   = 0;
    int  cyc   = 0;
    bit  resp  = 1'b0;
    wready = 1'b1;
    while (!resp && cyc < 40) begin
      awready = (cyc >= awdly);
      #1;
      if (bready) begin
        resp = 1'b1;
      end else begin
        check("wr_addr_ok_busy", wr_addr_ok, 1'b0);
        if (wvalid && wready && beats < LW) begin
          check("wdata", wdata, exp_words[beats]);
          check("wlast", wlast, beats == nbeats - 1);
          check("wstrb_wid", {wstrb, wid}, {es, 5'd2});
          beats++;
        end
        if (awvalid && awready) begin
          check("awaddr", awaddr, ea);
          check("awlen_awid", {awlen, awid}, {elen, 5'd2});
          aws++;
        end
        @(negedge clk);
      end
      cyc++;
    end
    check("w_beats", beats, nbeats);
    check("aw_count", aws, 1);
    check("bready_reached", resp, 1'b1);
    awready = 1'b0; wready = 1'b0;
    check("wr_done_before_b", wr_done, 1'b0);
    bvalid = 1'b1; bid = 5'd2;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    check("wr_done_pulse", wr_done, 1'b1);
    check("wr_addr_ok_after_b", wr_addr_ok, 1'b1);
    @(negedge clk);
    #1;
    check("wr_done_single", wr_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // AR arbitration table; rr_ptr carries across rows (starts at 0)
    vecs[0] = '{2'b11, 3'b100, 3'b100, 2'b01, 5'd0, 4'd3};
    vecs[1] = '{2'b11, 3'b100, 3'b100, 2'b10, 5'd1, 4'd3};
    vecs[2] = '{2'b11, 3'b100, 3'b100, 2'b01, 5'd0, 4'd3};
    vecs[3] = '{2'b11, 3'b100, 3'b100, 2'b10, 5'd1, 4'd3};
    vecs[4] = '{2'b10, 3'b100, 3'b000, 2'b10, 5'd1, 4'd0};
    vecs[5] = '{2'b10, 3'b000, 3'b000, 2'b10, 5'd1, 4'd0};
    vecs[6] = '{2'b01, 3'b000, 3'b100, 2'b01, 5'd0, 4'd0};
    vecs[7] = '{2'b01, 3'b101, 3'b100, 2'b01, 5'd0, 4'd0};
    vecs[8] = '{2'b11, 3'b100, 3'b100, 2'b10, 5'd1, 4'd3};

    resetn = 1'b0;
    rd_req = 2'b11; rd_addr = '0; rd_type = 6'b100100;
    wr_req = 1'b1; wr_addr = '0; wr_type = 3'b100; wr_data = '0; wr_wstrb = 4'hF;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd_addr_ok", rd_addr_ok, 2'b00);
    check("rst_wr_addr_ok", wr_addr_ok, 1'b0);
    check("rst_valids", {arvalid, awvalid, wvalid, bready, wr_done}, 5'b0);
    rd_req = '0; wr_req = 1'b0; resetn = 1'b1;
    #1;
    check("post_rst_wr_addr_ok", wr_addr_ok, 1'b1);
    check("post_rst_arvalid", arvalid, 1'b0);
    check("rready", rready, 1'b1);

    // Round-robin AR vectors
    for (int i = 0; i < 9; i++) begin
      ar_txn(vecs[i].req, {vecs[i].t1, vecs[i].t0},
             {32'h0000_2000 + 32'(i * 16), 32'h0000_1000 + 32'(i * 16)},
             vecs[i].exp_ok, vecs[i].exp_id, vecs[i].exp_len,
             (vecs[i].exp_id == 5'd0) ? 32'h0000_1000 + 32'(i * 16)
                                      : 32'h0000_2000 + 32'(i * 16));
    end

    // R routing: four beats for requester 1, then a stray id and a requester-0 beat
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rvalid = 1'b1; rid = 5'd1; rdata = 32'hD000_0000 + 32'(k); rlast = (k == 3);
      #1;
      check("r_data_ok", rd_data_ok, 2'b10);
      check("r_last", rd_last, (k == 3) ? 2'b10 : 2'b00);
      check("r_rdata", rd_rdata, 32'hD000_0000 + 32'(k));
    end
    @(negedge clk);
    rid = 5'd3; rlast = 1'b1;
    #1;
    check("r_stray_id", {rd_data_ok, rd_last}, 4'b0000);
    @(negedge clk);
    rid = 5'd0; rlast = 1'b1;
    #1;
    check("r_req0", {rd_data_ok, rd_last}, 4'b0101);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("r_idle", {rd_data_ok, rd_last}, 4'b0000);

    // Line write with awready withheld for three cycles
    exp_words = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};
    start_write(32'h1C00_0040, 3'b100, 4'hF);
    finish_write(32'h1C00_0040, 4'd3, 4'hF, 4, 3);

    // Single-word write
    exp_words = '{32'h1122_3344, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    start_write(32'h1C00_0100, 3'b000, 4'b0011);
    finish_write(32'h1C00_0100, 4'd0, 4'b0011, 1, 0);

    // RAW: read to the line of a write accepted in the same cycle, then pending
    exp_words = '{32'hB0B0_0000, 32'hB1B1_0001, 32'hB2B2_0002, 32'hB3B3_0003};
    @(negedge clk);
    rd_req = 2'b01; rd_type = 6'b100100; rd_addr = {32'h0, 32'h1C00_004C};
    wr_req = 1'b1; wr_addr = 32'h1C00_0040; wr_type = 3'b100; wr_wstrb = 4'hF;
    wr_data = {exp_words[3], exp_words[2], exp_words[1], exp_words[0]};
    awready = 1'b0; wready = 1'b0;
    #1;
    check("raw_wr_ok", wr_addr_ok, 1'b1);
`ifdef BRIDGE_RAW_CHECK_EN
    check("raw_same_cycle_blocked", rd_addr_ok, 2'b00);
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    check("raw_pending_blocked", rd_addr_ok, 2'b00);
    @(negedge clk);
    #1;
    check("raw_pending_blocked2", {rd_addr_ok, arvalid}, 3'b000);
    rd_req = 2'b00;
`else
    check("raw_off_accepted", rd_addr_ok, 2'b01);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 2'b00;
    #1;
    check("raw_off_araddr", {arvalid, araddr}, {1'b1, 32'h1C00_004C});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
`endif
    // Different line from requester 1 proceeds while the write is pending
    ar_txn(2'b10, 6'b100100, {32'h1C00_0080, 32'h0}, 2'b10, 5'd1, 4'd3, 32'h1C00_0080);
    finish_write(32'h1C00_0040, 4'd3, 4'hF, 4, 0);
    // Once B has returned the same-line read is accepted
    ar_txn(2'b01, 6'b100100, {32'h0, 32'h1C00_004C}, 2'b01, 5'd0, 4'd3, 32'h1C00_004C);

    // Reset in the middle of a line write (beat 2 on the bus)
    exp_words = '{32'hC0C0_0000, 32'hC1C1_0001, 32'hC2C2_0002, 32'hC3C3_0003};
    start_write(32'h1C00_0200, 3'b100, 4'hF);
    wready = 1'b1; awready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("mid_burst_beat2", {wvalid, wdata}, {1'b1, 32'hC2C2_0002});
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_valids", {awvalid, wvalid, bready}, 3'b000);
    check("rst_mid_wr_addr_ok", wr_addr_ok, 1'b0);
    resetn = 1'b1; wready = 1'b0;
    #1;
    check("after_rst_wr_addr_ok", wr_addr_ok, 1'b1);
    @(negedge clk);
    #1;
    check("after_rst_idle", {awvalid, wvalid, arvalid, wr_done}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
